multi_wave_gen: RTL and testbench
=================================

Name: multi_wave_gen

Overview:
- Parametrised successor to the fixed 8-bit sawtooth counter: phase-accumulator (DDS-style) waveform generator.
- Output width, accumulator width and frequency are programmable; selectable shapes are saw-up, saw-down, triangle and square with duty control.
- Configuration is loaded through a valid/ready handshake and applied glitch-free at the period boundary.
- Feeds the synth mixer/DAC path in place of the single-shape oscillators.

Parameters:
- OUT_W, 8, output sample width in bits (>=2).
- ACC_W, 16, phase accumulator width (>=OUT_W); also the tuning word width.
- FTW_RESET, 256, tuning word active after reset (256 with ACC_W=16 gives a 256-cycle period).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  accumulator advance enable; when low, phase and outputs hold.
- sync_clr  in  1  synchronous phase restart (hard sync).
- cfg_valid  in  1  new configuration offered.
- cfg_ready  out  1  high when the pending slot is free.
- ftw_in  in  ACC_W  frequency tuning word.
- mode_in  in  2  shape: 0 saw-up, 1 saw-down, 2 triangle, 3 square.
- duty_in  in  OUT_W  square threshold.
- wave_out  out  OUT_W  registered sample.
- wrap_pulse  out  1  one-cycle strobe per period.

Behaviour:
- Reset (async, reset_n=0):
  - acc=0, pending=0, cfg_ready=1, wave_out=0, wrap_pulse=0.
  - Active ftw=FTW_RESET, mode=0, duty=2^(OUT_W-1).
- Accumulator, priority sync_clr > en:
  - sync_clr=1: acc<=0, no wrap_pulse.
  - else en=1: acc<=(acc+ftw_act) mod 2^ACC_W; carry out = wrap.
  - else: hold.
- Phase p = acc[ACC_W-1 -: OUT_W]. Shaping of p:
  - saw-up: p.
  - saw-down: ~p.
  - triangle: t={p[OUT_W-2:0],1'b0}; out = p[MSB] ? ~t : t.
  - square: out = (p < duty_act) ? all-ones : 0. duty=0 gives constant 0; a duty value above every p gives constant all-ones.
- Latency: wave_out and wrap_pulse are registered 1 cycle after the acc value and carry that produced them. With en low they hold their last value, and wrap_pulse stays 0 after its strobe.
- Config handshake:
  - Accept when cfg_valid&&cfg_ready: ftw_in, mode_in and duty_in are latched into the pending slot, pending<=1, cfg_ready<=0 next cycle.
  - cfg_valid while cfg_ready=0 is not accepted; the source holds until ready.
- Apply (pending->active, pending<=0, cfg_ready<=1 next cycle). Condition uses the pre-edge value of pending, when any of:
  - wrap occurs this cycle;
  - sync_clr=1;
  - en=0;
  - ftw_act==0.
- The new ftw is used from the next increment.
- Simultaneous accept and wrap: the new config goes to pending and waits for the following apply condition. It is never applied in its accept cycle.
- ftw=0: phase frozen, wrap never fires, next accepted config applies one cycle after acceptance.
- Mode/duty change takes effect on wave_out one cycle after apply, so there are no mid-period shape glitches while running.
- Reset mid-operation discards pending config and returns to the FTW_RESET defaults.
- Legacy equivalence: ACC_W=8, OUT_W=8, FTW_RESET=1, mode 0 reproduces 0..255 counting with wrap to 0.

Decomposition:
- Shared package wavegen_pkg:
  - mode typedef (enum logic[1:0]: MODE_SAW_UP, MODE_SAW_DN, MODE_TRI, MODE_SQR);
  - default width constants.
- Sub-module wave_shaper: combinational p, mode, duty -> sample. Reused by future multi-voice banks.
- Top level holds the accumulator, config slot and output registers.

Test Plan:
- Reset defaults: ACC_W=16, OUT_W=8, en=1 -> wave_out 0,0,1,2,...,255,0. wrap_pulse is high exactly once per 256 cycles, in the cycle wave_out returns to 0.
- Triangle with ftw=512 -> wave_out 0,0,4,8,...,252,255,251,...,3, then repeats. Period 128 cycles.
- Square, duty=64, ftw=256 -> all-ones for 64 cycles then 0 for 192. Duty=0 gives constant 0.
- Config change while running: accept ftw=1024 mid-period -> cfg_ready low and the old ftw continues until wrap. The step becomes 4 after wrap and cfg_ready returns high.
- Accept coinciding with wrap -> not applied at that wrap; applied at the next wrap.
- sync_clr pulse at acc=0x8000 -> wave_out 0 two cycles later with no wrap_pulse. Asserting reset_n low mid-period with pending set -> outputs 0, cfg_ready=1, FTW_RESET restored.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared types and default widths for the phase-accumulator waveform generators.
package wavegen_pkg;

  typedef enum logic [1:0] {
    MODE_SAW_UP = 2'd0,
    MODE_SAW_DN = 2'd1,
    MODE_TRI    = 2'd2,
    MODE_SQR    = 2'd3
  } wave_mode_e;

  localparam int unsigned DefOutW     = 8;
  localparam int unsigned DefAccW     = 16;
  localparam int unsigned DefFtwReset = 256;

endpackage

// File: rtl/wave_shaper.sv
// Combinational phase-to-sample shaper: saw-up, saw-down, triangle, square with duty.
module wave_shaper
  import wavegen_pkg::*;
#(
  parameter int unsigned OUT_W = DefOutW
) (
  input  logic [OUT_W-1:0] phase,
  input  wave_mode_e       mode,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] sample
);

  logic [OUT_W-1:0] tri_t;

  always_comb begin
    sample = '0;
    tri_t  = {phase[OUT_W-2:0], 1'b0};
    unique case (mode)
      MODE_SAW_UP: sample = phase;
      MODE_SAW_DN: sample = ~phase;
      // Rising half doubles the phase; falling half mirrors it.
      MODE_TRI:    sample = phase[OUT_W-1] ? ~tri_t : tri_t;
      MODE_SQR:    sample = (phase < duty) ? '1 : '0;
    endcase
  end

endmodule

// File: rtl/multi_wave_gen.sv
// DDS-style multi-shape waveform generator with a handshaked config slot that is
// applied only at a period boundary (or whenever the phase is not advancing).
module multi_wave_gen
  import wavegen_pkg::*;
#(
  parameter int unsigned OUT_W     = DefOutW,
  parameter int unsigned ACC_W     = DefAccW,
  parameter int unsigned FTW_RESET = DefFtwReset
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] ftw_in,
  input  logic [1:0]       mode_in,
  input  logic [OUT_W-1:0] duty_in,
  output logic [OUT_W-1:0] wave_out,
  output logic             wrap_pulse
);

  localparam logic [OUT_W-1:0] DutyReset = {1'b1, {(OUT_W-1){1'b0}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;
  logic             arrived_q, arrived_d;  // current acc value was reached via carry
  logic [OUT_W-1:0] wave_q, wave_d;
  logic             wrap_q, wrap_d;
  logic             wrap_now, adv, accept, apply;

  logic             pend_q;
  logic [ACC_W-1:0] pend_ftw_q, ftw_act_q;
  wave_mode_e       pend_mode_q, mode_act_q;
  logic [OUT_W-1:0] pend_duty_q, duty_act_q;
  logic [OUT_W-1:0] sample;

  wave_shaper #(
    .OUT_W (OUT_W)
  ) u_shaper (
    .phase  (acc_q[ACC_W-1 -: OUT_W]),
    .mode   (mode_act_q),
    .duty   (duty_act_q),
    .sample (sample)
  );

  always_comb begin
    sum       = {1'b0, acc_q} + {1'b0, ftw_act_q};
    wrap_now  = en & ~sync_clr & sum[ACC_W];
    adv       = en | sync_clr;
    accept    = cfg_valid & ~pend_q;
    // Accept and apply are exclusive: apply needs a full slot, accept an empty one.
    apply     = pend_q & (wrap_now | sync_clr | ~en | (ftw_act_q == '0));
    acc_d     = acc_q;
    arrived_d = arrived_q;
    if (sync_clr) begin
      acc_d     = '0;
      arrived_d = 1'b0;
    end else if (en) begin
      acc_d     = sum[ACC_W-1:0];
      arrived_d = sum[ACC_W];
    end
    wave_d = adv ? sample : wave_q;
    wrap_d = adv & arrived_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q     <= '0;
      arrived_q <= 1'b0;
      wave_q    <= '0;
      wrap_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      arrived_q <= arrived_d;
      wave_q    <= wave_d;
      wrap_q    <= wrap_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      pend_ftw_q  <= '0;
      pend_mode_q <= MODE_SAW_UP;
      pend_duty_q <= '0;
      ftw_act_q   <= ACC_W'(FTW_RESET);
      mode_act_q  <= MODE_SAW_UP;
      duty_act_q  <= DutyReset;
    end else if (apply) begin
      pend_q     <= 1'b0;
      ftw_act_q  <= pend_ftw_q;
      mode_act_q <= pend_mode_q;
      duty_act_q <= pend_duty_q;
    end else if (accept) begin
      pend_q      <= 1'b1;
      pend_ftw_q  <= ftw_in;
      pend_mode_q <= wave_mode_e'(mode_in);
      pend_duty_q <= duty_in;
    end
  end

  assign cfg_ready  = ~pend_q;
  assign wave_out   = wave_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_multi_wave_gen.sv
// Randomised and directed checks of multi_wave_gen against a cycle-level reference model.
module tb_multi_wave_gen;

  localparam int OUT_W     = 8;
  localparam int ACC_W     = 16;
  localparam int FTW_RESET = 256;
  localparam int MAXV      = 255;
  localparam int HALF      = 128;
  localparam int MODV      = 65536;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0, sync_clr = 1'b0, cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] ftw_in = '0;
  logic [1:0]  mode_in = '0;
  logic [7:0]  duty_in = '0;
  logic [7:0]  wave_out;
  logic        wrap_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_acc, m_ftw, m_mode, m_duty, m_wave;
  int p_ftw, p_mode, p_duty;
  bit m_pend, m_wrap, m_arrived;

  always #5 clk = ~clk;

  multi_wave_gen #(
    .OUT_W     (OUT_W),
    .ACC_W     (ACC_W),
    .FTW_RESET (FTW_RESET)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .sync_clr   (sync_clr),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .ftw_in     (ftw_in),
    .mode_in    (mode_in),
    .duty_in    (duty_in),
    .wave_out   (wave_out),
    .wrap_pulse (wrap_pulse)
  );

  function automatic int shape(int p, int mode, int duty);
    case (mode)
      0:       return p;
      1:       return MAXV - p;
      2:       return (p < HALF) ? 2 * p : MAXV - 2 * (p - HALF);
      default: return (p < duty) ? MAXV : 0;
    endcase
  endfunction

  task automatic model_reset();
    m_acc = 0; m_ftw = FTW_RESET; m_mode = 0; m_duty = HALF;
    m_pend = 0; m_wave = 0; m_wrap = 0; m_arrived = 0;
    p_ftw = 0; p_mode = 0; p_duty = 0;
  endtask

  // Drive one cycle of inputs and advance the reference model across the edge.
  task automatic step(input logic e, input logic s, input logic v, input int f, input int md,
                      input int d);
    int  sum, nacc, nwave;
    bit  wrapped, adv, acc_ok, apply, nwrap, narr;
    @(negedge clk);
    en = e; sync_clr = s; cfg_valid = v;
    ftw_in = 16'(f); mode_in = 2'(md); duty_in = 8'(d);
    sum     = m_acc + m_ftw;
    wrapped = e && !s && (sum >= MODV);
    adv     = e || s;
    nwave   = adv ? shape(m_acc / 256, m_mode, m_duty) : m_wave;
    nwrap   = adv && m_arrived;
    nacc    = s ? 0 : (e ? sum % MODV : m_acc);
    narr    = s ? 1'b0 : (e ? wrapped : m_arrived);
    acc_ok  = v && !m_pend;
    apply   = m_pend && (wrapped || s || !e || m_ftw == 0);
    @(posedge clk);
    #1;
    m_acc = nacc; m_wave = nwave; m_wrap = nwrap; m_arrived = narr;
    if (apply) begin
      m_ftw = p_ftw; m_mode = p_mode; m_duty = p_duty; m_pend = 0;
    end else if (acc_ok) begin
      p_ftw = f; p_mode = md; p_duty = d; m_pend = 1;
    end
  endtask

  // Load a config while idle, then zero the phase.
  task automatic load_cfg(input int f, input int md, input int d);
    step(1'b0, 1'b0, 1'b1, f, md, d);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; en = 1'b0; sync_clr = 1'b0; cfg_valid = 1'b0;
    #1;
    n_tests++;
    if (wave_out !== 8'd0 || wrap_pulse !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset wave=%0d wrap=%0b ready=%0b, required 0/0/1",
               wave_out, wrap_pulse, cfg_ready);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_saw_default();
    int wraps = 0;
    for (int k = 1; k <= 600; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      n_tests++;
      if (wave_out !== 8'(m_wave) || wrap_pulse !== m_wrap || cfg_ready !== !m_pend) begin
        n_fail++;
        $display("FAIL saw k=%0d wave=%0d/%0d wrap=%0b/%0b ready=%0b/%0b", k, wave_out,
                 m_wave, wrap_pulse, m_wrap, cfg_ready, !m_pend);
      end
      if (wrap_pulse === 1'b1) begin
        wraps++;
        n_tests++;
        if (wave_out !== 8'd0) begin
          n_fail++;
          $display("FAIL saw_wrap_zero k=%0d wave=%0d required 0", k, wave_out);
        end
      end
      if (k == 100) begin
        n_tests++;
        if (wave_out !== 8'd99) begin
          n_fail++;
          $display("FAIL saw_k100 wave=%0d required 99", wave_out);
        end
      end
    end
    n_tests++;
    if (wraps != 2) begin
      n_fail++;
      $display("FAIL saw_wrap_count got=%0d required 2", wraps);
    end
  endtask

  task automatic test_triangle();
    load_cfg(512, 2, 0);
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      n_tests++;
      if (wave_out !== 8'(m_wave) || wrap_pulse !== m_wrap || cfg_ready !== !m_pend) begin
        n_fail++;
        $display("FAIL tri k=%0d wave=%0d/%0d wrap=%0b/%0b", k, wave_out, m_wave,
                 wrap_pulse, m_wrap);
      end
      if (k == 64 || k == 65 || k == 129) begin
        n_tests++;
        if (wave_out !== ((k == 64) ? 8'd252 : (k == 65) ? 8'd255 : 8'd0)) begin
          n_fail++;
          $display("FAIL tri_point k=%0d wave=%0d", k, wave_out);
        end
      end
    end
  endtask

  task automatic test_square();
    int ones = 0;
    load_cfg(256, 3, 64);
    for (int k = 1; k <= 256; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      n_tests++;
      if (wave_out !== 8'(m_wave)) begin
        n_fail++;
        $display("FAIL sqr64 k=%0d wave=%0d required %0d", k, wave_out, m_wave);
      end
      if (wave_out === 8'hff) ones++;
    end
    n_tests++;
    if (ones != 64) begin
      n_fail++;
      $display("FAIL sqr64_ones got=%0d required 64", ones);
    end
    ones = 0;
    load_cfg(256, 3, 0);
    for (int k = 1; k <= 256; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      if (wave_out !== 8'd0) ones++;
    end
    n_tests++;
    if (ones != 0) begin
      n_fail++;
      $display("FAIL sqr0_nonzero got=%0d required 0", ones);
    end
  endtask

  task automatic test_cfg_midperiod();
    bit seen = 0;
    load_cfg(256, 0, 0);
    for (int k = 0; k < 100; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 1024, 0, 0);
    n_tests++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ready_low ready=%0b required 0", cfg_ready);
    end
    for (int k = 0; k < 400 && !seen; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      n_tests++;
      if (wave_out !== 8'(m_wave) || wrap_pulse !== m_wrap || cfg_ready !== !m_pend) begin
        n_fail++;
        $display("FAIL mid k=%0d wave=%0d/%0d wrap=%0b/%0b ready=%0b/%0b", k, wave_out,
                 m_wave, wrap_pulse, m_wrap, cfg_ready, !m_pend);
      end
      if (wrap_pulse === 1'b1) seen = 1;
    end
    n_tests++;
    if (!seen || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wrap seen=%0b ready=%0b required 1/1", seen, cfg_ready);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    n_tests++;
    if (wave_out !== 8'd4) begin
      n_fail++;
      $display("FAIL mid_step4 wave=%0d required 4", wave_out);
    end
  endtask

  task automatic test_accept_at_wrap();
    bit seen = 0;
    for (int k = 0; k < 100 && (m_acc + m_ftw < MODV); k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 2048, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    n_tests++;
    if (wrap_pulse !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL aw_first wrap=%0b ready=%0b required 1/0", wrap_pulse, cfg_ready);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    n_tests++;
    if (wave_out !== 8'd4) begin
      n_fail++;
      $display("FAIL aw_old_step wave=%0d required 4", wave_out);
    end
    for (int k = 0; k < 100 && !seen; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      if (wrap_pulse === 1'b1) seen = 1;
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    n_tests++;
    if (!seen || wave_out !== 8'd8 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL aw_new_step seen=%0b wave=%0d ready=%0b required 1/8/1", seen, wave_out,
               cfg_ready);
    end
  endtask

  task automatic test_ftw_zero();
    load_cfg(0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 256, 0, 0);
    n_tests++;
    if (cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fz_accept ready=%0b required 0", cfg_ready);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    n_tests++;
    if (cfg_ready !== 1'b1 || wave_out !== 8'd0) begin
      n_fail++;
      $display("FAIL fz_apply ready=%0b wave=%0d required 1/0", cfg_ready, wave_out);
    end
  endtask

  task automatic test_sync_clr();
    load_cfg(256, 0, 0);
    for (int k = 0; k < 300 && m_acc != 16'h8000; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0);
    n_tests++;
    if (wave_out !== 8'd128) begin
      n_fail++;
      $display("FAIL sc_first wave=%0d required 128", wave_out);
    end
    step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    n_tests++;
    if (wave_out !== 8'd0 || wrap_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL sc_zero wave=%0d wrap=%0b required 0/0", wave_out, wrap_pulse);
    end
  endtask

  task automatic test_reset_mid();
    load_cfg(512, 2, 10);
    for (int k = 0; k < 37; k++) step(1'b1, 1'b0, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b1, 999, 3, 7);
    test_reset();
    for (int k = 1; k <= 300; k++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0, 0);
      n_tests++;
      if (wave_out !== 8'(m_wave) || wrap_pulse !== m_wrap || cfg_ready !== !m_pend) begin
        n_fail++;
        $display("FAIL rmid k=%0d wave=%0d/%0d wrap=%0b/%0b", k, wave_out, m_wave,
                 wrap_pulse, m_wrap);
      end
      if (k == 101) begin
        n_tests++;
        if (wave_out !== 8'd100) begin
          n_fail++;
          $display("FAIL rmid_default wave=%0d required 100", wave_out);
        end
      end
    end
  endtask

  task automatic test_random();
    int f;
    for (int k = 0; k < 4000; k++) begin
      case ($urandom_range(0, 4))
        0:       f = 0;
        1:       f = 256;
        2:       f = 1024;
        3:       f = $urandom_range(1, 4096);
        default: f = $urandom_range(0, 65535);
      endcase
      step(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 9) < 2), f, $urandom_range(0, 3), $urandom_range(0, 255));
      n_tests++;
      if (wave_out !== 8'(m_wave) || wrap_pulse !== m_wrap || cfg_ready !== !m_pend) begin
        n_fail++;
        $display("FAIL rand k=%0d wave=%0d/%0d wrap=%0b/%0b ready=%0b/%0b", k, wave_out,
                 m_wave, wrap_pulse, m_wrap, cfg_ready, !m_pend);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_saw_default();
    test_triangle();
    test_square();
    test_cfg_midperiod();
    test_accept_at_wrap();
    test_ftw_zero();
    test_sync_clr();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
